perf_counter_mmio: RTL and testbench

//  Memory-mapped performance-counter responder for the data-memory port. Sits beside the D-side arbiter.

---
 rtl/perf_counter_mmio_pkg.sv | 27 ++
 rtl/perf_counter_mmio_event_counter.sv | 57 +++++
 rtl/perf_counter_mmio.sv | 161 ++++++++++++++++
 tb/tb_perf_counter_mmio.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_mmio_pkg.sv
// Shared types, register-map constants and small decode helpers for the
// performance-counter MMIO responder.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } perf_state_t;

    localparam logic [6:0] CTRL_OFS        = 7'h40;
    localparam int         CTRL_FREEZE_BIT = 0;
    localparam int         CTRL_CLEAR_BIT  = 1;
    localparam int         CTR_STRIDE      = 4;

    // Word index of an in-window byte offset; CTRL lands on index 16,
    // which never collides with a counter index.
    function automatic logic [4:0] ofs_to_idx(input logic [6:0] ofs);
        return 5'(ofs / 7'(CTR_STRIDE));
    endfunction

    // Expand the four store byte lanes into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/perf_counter_mmio_event_counter.sv
// One performance counter: clear beats store, store beats the event
// increment, and freeze only suppresses the increment.
module perf_event_counter
    import perf_pkg::*;
#(
    parameter int CTR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    input  logic             freeze,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [CTR_W-1:0] wr_data,
    input  logic [3:0]       wr_be,
    output logic [CTR_W-1:0] value
);

    logic [CTR_W-1:0] value_q;
    logic [CTR_W-1:0] value_d;
    logic [CTR_W-1:0] mask_s;
    logic [CTR_W-1:0] merged_s;
    logic [31:0]      mask32_s;

    // Byte-lane merge of store data over the current count.
    always_comb begin
        mask32_s = be_to_mask(wr_be);
        mask_s   = mask32_s[CTR_W-1:0];
        merged_s = (wr_data & mask_s) | (value_q & ~mask_s);
    end

    // Next-count selection in priority order.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = {CTR_W{1'b0}};
        end else if (wr_en) begin
            value_d = merged_s;
        end else if (!freeze) begin
            value_d = value_q + CTR_W'(inc);
        end else begin
            value_d = value_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= {CTR_W{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/perf_counter_mmio.sv
// Memory-mapped performance counters on the data-memory port: window decode,
// snapshot read mux, three-state access FSM and the CTRL (freeze/clear) register.
module perf_counter_mmio
    import perf_pkg::*;
#(
    parameter int          NUM_CTRS  = 8,
    parameter int          CTR_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IF_ID_invalidate,
    input  logic                ID_EX_invalidate,
    input  logic [NUM_CTRS-2:0] event_pulse,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         mem_address,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_byte_enable,
    output logic                addr_hit,
    output logic [31:0]         mem_rdata,
    output logic                mem_resp
);

    perf_state_t state_q, state_d;
    logic        op_write_q, op_write_d;
    logic [6:0]  ofs_q, ofs_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_q, resp_d;
    logic        freeze_q, freeze_d;

    logic [CTR_W-1:0] ctr_val_s [NUM_CTRS];
    logic [1:0]       ctr_inc_s [NUM_CTRS];
    logic [4:0]       rd_idx_s;
    logic [6:0]       req_ofs_s;
    logic [31:0]      rd_val_s;
    logic             req_s;
    logic             commit_s;
    logic             ctrl_hit_s;
    logic             clr_s;
    logic             unused_s;

    assign addr_hit  = (mem_address[31:7] == BASE_ADDR[31:7]);
    assign req_s     = (mem_read | mem_write) & addr_hit;
    assign req_ofs_s = {mem_address[6:2], 2'b00};
    assign rd_idx_s  = ofs_to_idx(req_ofs_s);

    assign commit_s   = (state_q == ACCESS) & op_write_q;
    assign ctrl_hit_s = (ofs_q == CTRL_OFS);
    assign clr_s      = commit_s & ctrl_hit_s & be_q[0] & wdata_q[CTRL_CLEAR_BIT];
    assign unused_s   = ^{mem_address[1:0], wdata_q};

    // Snapshot mux: registered counter values as they stand before this edge.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (rd_idx_s == 5'(i)) begin
                rd_val_s = 32'(ctr_val_s[i]);
            end else begin
                rd_val_s = rd_val_s;
            end
        end
        if (req_ofs_s == CTRL_OFS) begin
            rd_val_s = {31'h0000_0000, freeze_q};
        end else begin
            rd_val_s = rd_val_s;
        end
    end

    // Access FSM: capture in IDLE, respond in ACCESS, one dead cycle in DONE.
    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        ofs_d      = ofs_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = 32'h0000_0000;
        resp_d     = 1'b0;
        freeze_d   = freeze_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d    = ACCESS;
                    op_write_d = mem_write & ~mem_read;
                    ofs_d      = req_ofs_s;
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    resp_d     = 1'b1;
                    rdata_d    = mem_read ? rd_val_s : 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (commit_s && ctrl_hit_s && be_q[0]) begin
                    freeze_d = wdata_q[CTRL_FREEZE_BIT];
                end else begin
                    freeze_d = freeze_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, latched request and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            ofs_q      <= 7'h00;
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'h0;
            rdata_q    <= 32'h0000_0000;
            resp_q     <= 1'b0;
            freeze_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            ofs_q      <= ofs_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            freeze_q   <= freeze_d;
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;

    for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
        if (g == 0) begin : g_flush
            assign ctr_inc_s[g] = {1'b0, IF_ID_invalidate} + {1'b0, ID_EX_invalidate};
        end else begin : g_event
            assign ctr_inc_s[g] = {1'b0, event_pulse[g-1]};
        end

        perf_event_counter #(
            .CTR_W(CTR_W)
        ) u_ctr (
            .clk    (clk),
            .rst    (rst),
            .inc    (ctr_inc_s[g]),
            .freeze (freeze_q),
            .clr    (clr_s),
            .wr_en  (commit_s && (ofs_to_idx(ofs_q) == 5'(g))),
            .wr_data(wdata_q[CTR_W-1:0]),
            .wr_be  (be_q),
            .value  (ctr_val_s[g])
        );
    end

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Directed bench for perf_counter_mmio: expected load data and response
// timing are queued at issue and checked by an independent response monitor.
module tb_perf_counter_mmio;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] CTRL = BASE + 32'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_id = 1'b0;
    logic        id_ex = 1'b0;
    logic [6:0]  ev = 7'h00;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_byte_enable = 4'h0;
    logic        addr_hit;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    perf_counter_mmio dut (
        .clk             (clk),
        .rst             (rst),
        .IF_ID_invalidate(if_id),
        .ID_EX_invalidate(id_ex),
        .event_pulse     (ev),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .addr_hit        (addr_hit),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response monitor: the capturing edge is cyc+1, which must be 2 edges after issue.
    always @(negedge clk) begin
        if (!rst && mem_resp) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp rdata %h want no resp", mem_rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "/rdata"}, mem_rdata, e.rdata);
                chk({e.name, "/latency"}, 32'(cyc + 1 - e.cyc), 32'd2);
            end
        end
    end

    task automatic pulse(input logic a, input logic b, input logic [6:0] e, input int n);
        @(posedge clk); #1;
        if_id = a; id_ex = b; ev = e;
        repeat (n) @(posedge clk);
        #1;
        if_id = 1'b0; id_ex = 1'b0; ev = 7'h00;
    endtask

    task automatic access(input string name, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] exp, input bit hit, input logic [6:0] e);
        bit seen;
        @(posedge clk); #1;
        mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        mem_read = !wr; mem_write = wr; ev = e;
        if (hit) sb_q.push_back('{exp, cyc, name});
        #1;
        chk({name, "/addr_hit"}, {31'h0, addr_hit}, {31'h0, hit});
        if (hit) begin
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge clk);
                seen = mem_resp;
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL %s/timeout: got no resp want resp", name);
            end
        end else begin
            repeat (4) @(negedge clk);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; ev = 7'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        mem_address = BASE;
        #2;
        chk("reset/resp", {31'h0, mem_resp}, 32'h0);
        chk("reset/rdata", mem_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Flush counting: 3 cycles of +2, then 2 cycles of +1.
        pulse(1'b1, 1'b1, 7'h00, 3);
        pulse(1'b1, 1'b0, 7'h00, 2);
        access("t1_ctr0", 1'b0, BASE, 32'h0, 4'h0, 32'd8, 1'b1, 7'h00);
        access("t1_ctr1", 1'b0, BASE + 32'h4, 32'h0, 4'h0, 32'd0, 1'b1, 7'h00);

        // Wrap: all-ones + 2 -> 1.
        access("t2_wr", 1'b1, BASE, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 7'h00);
        pulse(1'b1, 1'b1, 7'h00, 1);
        access("t2_ctr0", 1'b0, BASE, 32'h0, 4'h0, 32'd1, 1'b1, 7'h00);

        // Freeze holds counters; unfreeze resumes counting.
        access("t3_frz", 1'b1, CTRL, 32'h1, 4'hF, 32'h0, 1'b1, 7'h00);
        access("t3_ctrl", 1'b0, CTRL, 32'h0, 4'h0, 32'd1, 1'b1, 7'h00);
        pulse(1'b0, 1'b0, 7'h7F, 5);
        access("t3_ctr1_frz", 1'b0, BASE + 32'h4, 32'h0, 4'h0, 32'd0, 1'b1, 7'h00);
        access("t3_ctr7_frz", 1'b0, BASE + 32'h1C, 32'h0, 4'h0, 32'd0, 1'b1, 7'h00);
        access("t3_unfrz", 1'b1, CTRL, 32'h0, 4'hF, 32'h0, 1'b1, 7'h00);
        pulse(1'b0, 1'b0, 7'h7F, 1);
        access("t3_ctr1", 1'b0, BASE + 32'h4, 32'h0, 4'h0, 32'd1, 1'b1, 7'h00);
        access("t3_ctr7", 1'b0, BASE + 32'h1C, 32'h0, 4'h0, 32'd1, 1'b1, 7'h00);
        access("t3_ctr0", 1'b0, BASE, 32'h0, 4'h0, 32'd1, 1'b1, 7'h00);

        // Byte-lane store wins over a same-cycle event on ctr3.
        access("t4_wr", 1'b1, BASE + 32'hC, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 7'h00);
        access("t4_wrb", 1'b1, BASE + 32'hC, 32'h0000_00AB, 4'b0001, 32'h0, 1'b1, 7'h04);
        access("t4_ctr3", 1'b0, BASE + 32'hC, 32'h0, 4'h0, 32'h1234_56AB, 1'b1, 7'h00);
        access("t4_ctr2", 1'b0, BASE + 32'h8, 32'h0, 4'h0, 32'd1, 1'b1, 7'h00);

        // Holes, out-of-window, clear_all.
        access("t5_hole", 1'b0, BASE + 32'h60, 32'h0, 4'h0, 32'h0, 1'b1, 7'h00);
        access("t5_out", 1'b0, BASE - 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, 7'h00);
        access("t5_clr", 1'b1, CTRL, 32'h2, 4'hF, 32'h0, 1'b1, 7'h00);
        access("t5_ctr0", 1'b0, BASE, 32'h0, 4'h0, 32'h0, 1'b1, 7'h00);
        access("t5_ctr3", 1'b0, BASE + 32'hC, 32'h0, 4'h0, 32'h0, 1'b1, 7'h00);
        access("t5_ctrl", 1'b0, CTRL, 32'h0, 4'h0, 32'h0, 1'b1, 7'h00);

        // Reset in the middle of an access, then a held request after release.
        pulse(1'b1, 1'b0, 7'h7F, 2);
        @(posedge clk); #1;
        mem_address = BASE + 32'h4; mem_read = 1'b1;
        sb_q.push_back('{32'd2, cyc, "t6_pre"});
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = mem_resp;
        end
        chk("t6_pre/seen", {31'h0, seen}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst/resp", {31'h0, mem_resp}, 32'h0);
        chk("t6_rst/rdata", mem_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.push_back('{32'd0, cyc, "t6_held"});
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = mem_resp;
        end
        chk("t6_held/seen", {31'h0, seen}, 32'h1);
        @(posedge clk); #1;
        mem_read = 1'b0;
        access("t6_ctr0", 1'b0, BASE, 32'h0, 4'h0, 32'h0, 1'b1, 7'h00);

        repeat (4) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
